uart_rx_stop_check: RTL and testbench
=====================================

# uart_rx_stop_check

UART receiver stop-bit checker. Runs in the oversampling clock domain, on the prescaled clock. When the RX FSM asserts the enable during the stop-bit slot, it compares the majority-sampled line value against the required idle level (1). It reports a framing (stop) error to the FSM / error-status logic.

## Interface
Parameters: none.

Ports:
- clk_based_on_prescale  input  1  prescaled RX sampling clock; all state updates on its rising edge
- asy_reset  input  1  reset; asynchronous, active-low (0 = reset asserted)
- sampled_data  input  1  sampled RX bit value from the data sampler, stable at the clock edge
- stop_check_enable  input  1  RX FSM strobe: current sampled bit is the stop bit
- stop_error  output  1  registered stop/framing error flag; 1 = stop bit sampled as 0

## Operation
- The only state is one flip-flop, which drives stop_error directly.
- Asynchronous reset: while asy_reset = 0, stop_error = 0 immediately, independent of the clock.
- Rising edge of clk_based_on_prescale with asy_reset = 1:
  - stop_check_enable = 1, sampled_data = 1: stop_error <= 0 (valid stop bit).
  - stop_check_enable = 1, sampled_data = 0: stop_error <= 1 (framing error).
  - stop_check_enable = 0: stop_error <= 0. The flag is cleared whenever the check is not enabled, so an error is never held past the enable window.
- Equivalently: stop_error <= stop_check_enable & ~sampled_data.
- sampled_data is ignored when stop_check_enable = 0.
- No X propagation: undefined inputs during reset have no effect. After reset release, the output is defined from the first clock edge.

## Timing
- Latency: 1 clock. stop_error reflects the inputs present at the previous rising edge.
- Output is glitch-free, driven only from the flip-flop with no combinational path from the inputs.
- Enable held for N cycles: the check repeats every cycle. stop_error tracks ~sampled_data, one cycle delayed, for each cycle of the window.
- Enable deasserted: stop_error returns to 0 on the next rising edge.
- Reset asserted mid-check: stop_error goes to 0 asynchronously and stays 0 until reset releases.
- Reset released: the first evaluation happens at the next rising edge.
- Reset release coinciding with a clock edge: that edge is not guaranteed to be evaluated. The FSM must not assert stop_check_enable on the release cycle.
- The consumer (RX FSM) samples stop_error one cycle after asserting stop_check_enable.

## Test plan
- Reset: asy_reset = 0 with sampled_data = 1 and enable = 0, clock running -> stop_error = 0 throughout. Release asy_reset = 1 -> stop_error remains 0.
- Valid stop bit: enable = 1, sampled_data = 1 for two edges -> stop_error = 0 after each edge.
- Framing error: enable = 1, sampled_data changes 1 -> 0 -> stop_error = 1 after the next rising edge. It stays 1 while both are held.
- Enable drop clears the flag: from the error state, enable = 0 with sampled_data = 0, then sampled_data = 1 -> stop_error = 0 after the first edge and stays 0.
- Async reset mid-error: with stop_error = 1, drive asy_reset = 0 between clock edges -> stop_error = 0 immediately, before any edge. Drive asy_reset = 1 with enable = 0 -> stop_error stays 0.
- Per-cycle tracking: enable = 1, sampled_data sequence 1, 0, 1, 0 on successive edges -> stop_error sequence 0, 1, 0, 1, each one cycle later.

Source files
------------

// File: rtl/uart_rx_stop_check.sv
// uart_rx_stop_check: UART RX stop-bit (framing) checker.
// Flags a stop bit sampled low while the RX FSM strobes the check.
//
// Ports:
//   clk_based_on_prescale - prescaled RX sampling clock
//   asy_reset             - async reset, active low
//   sampled_data          - majority-sampled RX bit
//   stop_check_enable     - FSM strobe: current bit is the stop bit
//   stop_error            - registered framing error flag
module uart_rx_stop_check (
  input  logic clk_based_on_prescale,
  input  logic asy_reset,
  input  logic sampled_data,
  input  logic stop_check_enable,
  output logic stop_error
);

  // Cleared whenever the check is not enabled, so the flag never
  // outlives the stop-bit window.
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      stop_error <= 1'b0;
    end else begin
      stop_error <= stop_check_enable & ~sampled_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_stop_check.sv
// tb_uart_rx_stop_check: directed bench for uart_rx_stop_check.
// Inputs change on the falling edge; outputs sampled 1 after rising.
module tb_uart_rx_stop_check;

  logic clk;
  logic rst_n;
  logic sd;
  logic en;
  logic err;

  int checks = 0;
  int errors = 0;

  uart_rx_stop_check dut (
    .clk_based_on_prescale(clk),
    .asy_reset(rst_n),
    .sampled_data(sd),
    .stop_check_enable(en),
    .stop_error(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic exp);
    checks++;
    assert (err === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, err, exp);
    end
  endtask

  task automatic drive(input logic e, input logic d);
    @(negedge clk);
    en = e;
    sd = d;
  endtask

  task automatic edge_chk(input string tag, input logic exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    sd    = 1'b1;
    en    = 1'b0;
    #1;
    chk("rst_imm", 1'b0);
    edge_chk("rst_edge0", 1'b0);
    edge_chk("rst_edge1", 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    edge_chk("rel_idle", 1'b0);

    drive(1'b1, 1'b1);
    edge_chk("valid_stop0", 1'b0);
    edge_chk("valid_stop1", 1'b0);

    drive(1'b1, 1'b0);
    edge_chk("frame_err", 1'b1);
    edge_chk("frame_err_hold", 1'b1);

    drive(1'b0, 1'b0);
    edge_chk("en_drop_d0", 1'b0);
    drive(1'b0, 1'b1);
    edge_chk("en_drop_d1", 1'b0);

    drive(1'b1, 1'b0);
    edge_chk("pre_rst_err", 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst", 1'b0);
    edge_chk("rst_held", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    edge_chk("rst_rel_noen", 1'b0);

    drive(1'b1, 1'b1);
    edge_chk("track0", 1'b0);
    drive(1'b1, 1'b0);
    edge_chk("track1", 1'b1);
    drive(1'b1, 1'b1);
    edge_chk("track2", 1'b0);
    drive(1'b1, 1'b0);
    edge_chk("track3", 1'b1);
    drive(1'b0, 1'b0);
    edge_chk("track_end", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
